// File: rtl/selector81_arbiter.sv
// selector81_arbiter: round-robin arbiter owning a shared 8:1 data selector with a bounded hold time
module selector81_arbiter #(
    parameter int HOLD_MAX = 15
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic [7:0] iReq,
    input  logic       iDone,
    input  logic [7:0] iC,
    output logic       oS2,
    output logic       oS1,
    output logic       oS0,
    output logic [7:0] oGnt,
    output logic       oValid,
    output logic       oZ,
    output logic       oTimeout
);
    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    localparam logic [3:0] LAST = 4'(HOLD_MAX - 1);

    state_t     state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [2:0] ptr_q, ptr_d;
    logic [3:0] cnt_q, cnt_d;
    logic       tmo_q, tmo_d;
    logic [2:0] pick;
    logic       hit;
    logic [2:0] code;

    // first requester at or after the pointer, wrapping mod 8
    always_comb begin
        pick = ptr_q;
        hit  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!hit && iReq[ptr_q + 3'(i)]) begin
                pick = ptr_q + 3'(i);
                hit  = 1'b1;
            end
        end
    end

    // next state: owner release has priority over a dropped request, which beats the hold limit
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d = GRANT;
                    sel_d   = pick;
                    cnt_d   = 4'd0;
                end
            end
            GRANT: begin
                if (iDone || !iReq[sel_q]) begin
                    state_d = RELEASE;
                    ptr_d   = sel_q + 3'd1;
                end else if (cnt_q == LAST) begin
                    state_d = RELEASE;
                    ptr_d   = sel_q + 3'd1;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state registers, cleared asynchronously
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            ptr_q   <= 3'd0;
            cnt_q   <= 4'd0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    // grant outputs decode registers only; oZ is the one path from iC
    always_comb begin
        oValid   = (state_q == GRANT);
        code     = oValid ? sel_q : 3'd0;
        oGnt     = oValid ? (8'd1 << sel_q) : 8'd0;
        oZ       = oValid ? iC[sel_q] : 1'b0;
        oTimeout = tmo_q;
        {oS2, oS1, oS0} = code;
    end
endmodule

// File: tb/tb_selector81_arbiter.sv
// tb_selector81_arbiter: directed checks of the arbiter at HOLD_MAX 15, 4 and 1
module tb_selector81_arbiter;
    logic       iClk = 1'b0;
    logic       iRst = 1'b0;
    logic [7:0] iReq = 8'h00;
    logic       iDone = 1'b0;
    logic [7:0] iC = 8'h00;
    int         checks = 0;
    int         failures = 0;

    logic a_s2, a_s1, a_s0, a_v, a_z, a_t;
    logic b_s2, b_s1, b_s0, b_v, b_z, b_t;
    logic c_s2, c_s1, c_s0, c_v, c_z, c_t;
    logic [7:0] a_g, b_g, c_g;

    selector81_arbiter dut (
        .iClk(iClk), .iRst(iRst), .iReq(iReq), .iDone(iDone), .iC(iC),
        .oS2(a_s2), .oS1(a_s1), .oS0(a_s0), .oGnt(a_g), .oValid(a_v), .oZ(a_z), .oTimeout(a_t)
    );
    selector81_arbiter #(.HOLD_MAX(4)) dut4 (
        .iClk(iClk), .iRst(iRst), .iReq(iReq), .iDone(iDone), .iC(iC),
        .oS2(b_s2), .oS1(b_s1), .oS0(b_s0), .oGnt(b_g), .oValid(b_v), .oZ(b_z), .oTimeout(b_t)
    );
    selector81_arbiter #(.HOLD_MAX(1)) dut1 (
        .iClk(iClk), .iRst(iRst), .iReq(iReq), .iDone(iDone), .iC(iC),
        .oS2(c_s2), .oS1(c_s1), .oS0(c_s0), .oGnt(c_g), .oValid(c_v), .oZ(c_z), .oTimeout(c_t)
    );

    // {valid, gnt, sel code, z, timeout}
    wire [13:0] sa = {a_v, a_g, a_s2, a_s1, a_s0, a_z, a_t};
    wire [13:0] sb = {b_v, b_g, b_s2, b_s1, b_s0, b_z, b_t};
    wire [13:0] sc = {c_v, c_g, c_s2, c_s1, c_s0, c_z, c_t};
    localparam logic [13:0] OFF = 14'h0;
    localparam logic [13:0] OFF_TMO = 14'h1;

    always #5 iClk = ~iClk;

    task automatic tick;
        @(posedge iClk);
        #1;
    endtask

    task automatic do_reset;
        iRst = 1'b1; iReq = 8'h00; iDone = 1'b0; iC = 8'h00;
        #3;
        @(posedge iClk);
        #1;
        iRst = 1'b0;
    endtask

    task automatic test_reset;
        #1 iRst = 1'b1;
        #1;
        checks++;
        if (sa !== OFF) begin failures++; $display("FAIL reset_async got=%h exp=%h", sa, OFF); end
        @(posedge iClk);
        #1;
        checks++;
        if ({sa, sb, sc} !== {OFF, OFF, OFF}) begin failures++; $display("FAIL reset_held got=%h/%h/%h exp=0", sa, sb, sc); end
        iRst = 1'b0;
    endtask

    task automatic test_hold_timeout;
        do_reset();
        iReq = 8'h24;
        tick();
        checks++;
        if (sa !== {1'b1, 8'h04, 3'b010, 1'b0, 1'b0}) begin failures++; $display("FAIL first_grant_ch2 got=%h exp=%h", sa, {1'b1, 8'h04, 3'b010, 2'b00}); end
        for (int i = 2; i <= 15; i++) begin
            tick();
            checks++;
            if (sa !== {1'b1, 8'h04, 3'b010, 1'b0, 1'b0}) begin failures++; $display("FAIL hold_cycle_%0d got=%h", i, sa); end
        end
        tick();
        checks++;
        if (sa !== OFF_TMO) begin failures++; $display("FAIL timeout_release got=%h exp=%h", sa, OFF_TMO); end
        tick();
        checks++;
        if (sa !== OFF) begin failures++; $display("FAIL timeout_idle got=%h exp=%h", sa, OFF); end
        tick();
        checks++;
        if (sa !== {1'b1, 8'h20, 3'b101, 1'b0, 1'b0}) begin failures++; $display("FAIL next_grant_ch5 got=%h", sa); end
    endtask

    task automatic test_round_robin;
        logic [7:0] eg;
        logic [2:0] es;
        do_reset();
        iReq = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            eg = 8'h01 << (k % 8);
            es = 3'(k % 8);
            tick();
            checks++;
            if (sa !== {1'b1, eg, es, 1'b0, 1'b0}) begin failures++; $display("FAIL rr_grant_%0d got=%h exp=%h", k, sa, {1'b1, eg, es, 2'b00}); end
            iDone = 1'b1;
            tick();
            iDone = 1'b0;
            checks++;
            if (sa !== OFF) begin failures++; $display("FAIL rr_release_%0d got=%h", k, sa); end
            tick();
            checks++;
            if (sa !== OFF) begin failures++; $display("FAIL rr_idle_%0d got=%h", k, sa); end
        end
    endtask

    task automatic test_data_path;
        do_reset();
        iReq = 8'h80;
        iC = 8'h80;
        tick();
        checks++;
        if (sa !== {1'b1, 8'h80, 3'b111, 1'b1, 1'b0}) begin failures++; $display("FAIL ch7_z1 got=%h", sa); end
        iC = 8'h7F;
        #1;
        checks++;
        if (a_z !== 1'b0) begin failures++; $display("FAIL ch7_z0 got=%b exp=0", a_z); end
        iC = 8'h80;
        #1;
        checks++;
        if (a_z !== 1'b1) begin failures++; $display("FAIL ch7_z_back got=%b exp=1", a_z); end
        iDone = 1'b1;
        iC = 8'hFF;
        tick();
        iDone = 1'b0;
        iReq = 8'h00;
        checks++;
        if (sa !== OFF) begin failures++; $display("FAIL z_release got=%h", sa); end
        tick();
        checks++;
        if (sa !== OFF) begin failures++; $display("FAIL z_idle got=%h", sa); end
        iReq = 8'h81;
        tick();
        checks++;
        if (sa !== {1'b1, 8'h01, 3'b000, 1'b1, 1'b0}) begin failures++; $display("FAIL ptr_wrap_ch0 got=%h", sa); end
    endtask

    task automatic test_no_preempt;
        do_reset();
        iReq = 8'h04;
        tick();
        iReq = 8'h07;
        tick();
        tick();
        checks++;
        if (sa !== {1'b1, 8'h04, 3'b010, 1'b0, 1'b0}) begin failures++; $display("FAIL no_preempt got=%h", sa); end
        iReq = 8'h03;
        tick();
        checks++;
        if (sa !== OFF) begin failures++; $display("FAIL drop_release got=%h exp=%h", sa, OFF); end
        tick();
        tick();
        checks++;
        if (sa !== {1'b1, 8'h01, 3'b000, 1'b0, 1'b0}) begin failures++; $display("FAIL after_drop_ch0 got=%h", sa); end
    endtask

    task automatic test_hold4;
        do_reset();
        iReq = 8'h01;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                tick();
                checks++;
                if (sb !== {1'b1, 8'h01, 3'b000, 1'b0, 1'b0}) begin failures++; $display("FAIL h4_grant_%0d_%0d got=%h", r, i, sb); end
            end
            tick();
            checks++;
            if (sb !== OFF_TMO) begin failures++; $display("FAIL h4_release_%0d got=%h exp=%h", r, sb, OFF_TMO); end
            tick();
            checks++;
            if (sb !== OFF) begin failures++; $display("FAIL h4_idle_%0d got=%h", r, sb); end
        end
    endtask

    task automatic test_done_at_limit;
        do_reset();
        iReq = 8'h01;
        repeat (4) tick();
        checks++;
        if (sb !== {1'b1, 8'h01, 3'b000, 1'b0, 1'b0}) begin failures++; $display("FAIL h4_last_cycle got=%h", sb); end
        iDone = 1'b1;
        tick();
        iDone = 1'b0;
        checks++;
        if (sb !== OFF) begin failures++; $display("FAIL done_beats_timeout got=%h exp=%h", sb, OFF); end
    endtask

    task automatic test_hold1;
        do_reset();
        iReq = 8'h01;
        tick();
        checks++;
        if (sc !== {1'b1, 8'h01, 3'b000, 1'b0, 1'b0}) begin failures++; $display("FAIL h1_grant got=%h", sc); end
        tick();
        checks++;
        if (sc !== OFF_TMO) begin failures++; $display("FAIL h1_release got=%h exp=%h", sc, OFF_TMO); end
        tick();
        tick();
        checks++;
        if (sc !== {1'b1, 8'h01, 3'b000, 1'b0, 1'b0}) begin failures++; $display("FAIL h1_regrant got=%h", sc); end
    endtask

    task automatic test_reset_mid_grant;
        do_reset();
        iReq = 8'h08;
        tick();
        checks++;
        if (sa !== {1'b1, 8'h08, 3'b011, 1'b0, 1'b0}) begin failures++; $display("FAIL ch3_grant got=%h", sa); end
        #2 iRst = 1'b1;
        #1;
        checks++;
        if ({a_v, a_g} !== 9'h0) begin failures++; $display("FAIL async_drop got=%h exp=0", {a_v, a_g}); end
        tick();
        iRst = 1'b0;
        iReq = 8'h09;
        tick();
        checks++;
        if (sa !== {1'b1, 8'h01, 3'b000, 1'b0, 1'b0}) begin failures++; $display("FAIL restart_ch0 got=%h", sa); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_hold_timeout();
        test_round_robin();
        test_data_path();
        test_no_preempt();
        test_hold4();
        test_done_at_limit();
        test_hold1();
        test_reset_mid_grant();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/selector81_arbiter.md
SELECTOR81_ARBITER -- requirements
Module: selector81_arbiter

Interface
REQ-001 Parameter: HOLD_MAX, default 15, maximum number of consecutive cycles one requester may hold the grant (legal 1..15).
REQ-002 iClk  input  1  single clock; all state updates on its rising edge.
REQ-003 iRst  input  1  reset, asynchronous, active-high.
REQ-004 iReq  input  8  request lines, bit k = requester k wants the shared selector.
REQ-005 iDone  input  1  current owner releases the grant; sampled only in GRANT.
REQ-006 iC  input  8  data inputs of the shared 8:1 selector.
REQ-007 oS2, oS1, oS0  output  1 each  select code of the granted channel, oS2 = MSB.
REQ-008 oGnt  output  8  one-hot grant vector.
REQ-009 oValid  output  1  a grant is active this cycle.
REQ-010 oZ  output  1  selected data bit.
REQ-011 oTimeout  output  1  one-cycle pulse: previous grant was ended by the HOLD_MAX limit.

Function
REQ-012 FSM states: IDLE, GRANT, RELEASE; state, select code, pointer, hold counter and oTimeout are registers.
REQ-013 Pointer ptr (3 bits) is the highest-priority index; search order ptr, ptr+1, ..., ptr+7, all mod 8.
REQ-014 IDLE with iReq = 0: remain in IDLE, no register change except oTimeout <= 0.
REQ-015 IDLE with iReq != 0: at the next edge, the first set bit in search order becomes sel, state <= GRANT, counter <= 0.
REQ-016 Latency: a request seen in IDLE at edge N is granted (oValid = 1) in the cycle after edge N, i.e. 1 cycle.
REQ-017 GRANT outputs: oValid = 1, oGnt = one-hot(sel), {oS2,oS1,oS0} = sel; all are decoded from registers only (no input-to-output path).
REQ-018 oZ = iC[sel] when oValid = 1, else 0; combinational from iC.
REQ-019 In IDLE and RELEASE: oValid = 0, oGnt = 0, select code = 0, oZ = 0.
REQ-020 GRANT exit conditions, evaluated each edge with priority iDone > dropped request > timeout:
  - iDone = 1 -> RELEASE, oTimeout <= 0;
  - iReq[sel] = 0 -> RELEASE, oTimeout <= 0;
  - counter = HOLD_MAX-1 -> RELEASE, oTimeout <= 1;
  - otherwise stay in GRANT, counter <= counter + 1.
REQ-021 Maximum grant length is exactly HOLD_MAX cycles; HOLD_MAX = 1 gives single-cycle grants.
REQ-022 On every GRANT -> RELEASE transition: ptr <= sel + 1 mod 8 (sel 7 wraps to 0).
REQ-023 RELEASE lasts exactly one cycle, then IDLE; requests are ignored during RELEASE, and oTimeout is cleared at that exit edge.
REQ-024 The minimum gap between two grants is 2 dead cycles (RELEASE, IDLE).
REQ-025 Requests from non-owners during GRANT do not pre-empt the owner.
REQ-026 Simultaneous iDone and timeout: treated as iDone, so oTimeout stays 0.
REQ-027 A single persistent requester k is re-granted after each RELEASE/IDLE gap; the pointer does not starve it.

Reset
REQ-028 iRst = 1 forces, immediately and independent of iClk: state = IDLE, ptr = 0, sel = 0, counter = 0, oTimeout = 0.
REQ-029 The resulting outputs are oValid = 0, oGnt = 0, select code = 0, oZ = 0.
REQ-030 Reset asserted mid-GRANT drops the grant in the same cycle; after release, arbitration restarts from ptr = 0.

Verification
REQ-031 After reset, iReq = 8'b0010_0100, iDone held 0: first grant ch2 (oGnt = 8'h04, oS = 3'b010), held 15 cycles, oTimeout pulses, ptr = 3; next grant ch5 (8'h20).
REQ-032 iReq = 8'hFF, iDone pulsed in the first GRANT cycle each time: grant order 0,1,...,7,0 with a grant every 3 cycles.
REQ-033 Ch7 granted, iC = 8'h80, then iC[7] toggles: oZ follows iC[7]; oZ = 0 during RELEASE and IDLE.
REQ-034 HOLD_MAX = 4, iReq = 8'h01, no iDone: oValid pattern 1111 0 0 1111...; oTimeout = 1 in each RELEASE cycle.
REQ-035 iRst asserted between clock edges while ch3 is granted: oGnt = 0 and oValid = 0 before the next edge; after release with iReq = 8'h09, ch0 is granted first.
REQ-036 iDone = 1 on the same edge the counter reaches HOLD_MAX-1: RELEASE is entered and oTimeout stays 0.
